cmos_capture_ctrl: RTL and testbench
====================================

CMOS_CAPTURE_CTRL -- requirements
Module: cmos_capture_ctrl

Interface
REQ-001 The block SHALL have one clock `pclk` and a synchronous, active-high reset `rst`.
REQ-002 Parameter SKIP_FRAMES, default 10: number of warm-up frames discarded after reset (0..255).
REQ-003 Parameter H_ACT, default 1280: active pixels per line; expected bytes per line = 2*H_ACT.
REQ-004 Parameter V_ACT, default 720: active lines per frame.
REQ-005 Ports SHALL be:
- pclk  in  1  sensor byte clock; all logic on its rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  capture request; sampled only in IDLE.
- single  in  1  sampled with start; 1 = one frame then IDLE, 0 = continuous.
- stop  in  1  pulse; ends capture at the next frame boundary.
- vs_i  in  1  sensor vsync, active high; frame boundary = rising edge.
- de_i  in  1  sensor byte-valid.
- pdata_i  in  8  sensor byte.
- de_o  out  1  gated byte-valid to the 8-to-16 packer.
- pdata_o  out  8  gated byte.
- frame_start  out  1  one-cycle pulse.
- frame_done  out  1  one-cycle pulse.
- busy  out  1  high in any state other than IDLE.
- line_cnt  out  12  lines completed in the current frame.
- err_size  out  1  sticky framing error; cleared on an accepted start.

Function
REQ-006 vs_i SHALL be registered once (vs_d); rise = vs_i & ~vs_d; de_i falling edge SHALL be detected the same way.
REQ-007 The FSM SHALL have exactly four states: IDLE, SKIP, WAIT_VS, CAPTURE.
REQ-008 IDLE: an accepted start SHALL go to SKIP if warm-up is not yet done and SKIP_FRAMES>0, else to WAIT_VS; start and stop in the same cycle SHALL keep IDLE.
REQ-009 SKIP: each rise SHALL increment an 8-bit skip counter; the rise that makes the count equal SKIP_FRAMES SHALL set the warm-up-done flag and go to WAIT_VS.
REQ-010 WAIT_VS: a rise detected in cycle t SHALL enter CAPTURE at t+1, with frame_start=1 at t+1 and line_cnt and the byte counter cleared.
REQ-011 CAPTURE: de_o/pdata_o SHALL equal de_i/pdata_i delayed by exactly one cycle; outside CAPTURE de_o SHALL be 0 and pdata_o SHALL hold its last value.
REQ-012 If de_i is high on entry to CAPTURE, that partial line SHALL be suppressed (de_o=0) until de_i first goes low.
REQ-013 A 13-bit byte counter SHALL count gated bytes per line and saturate at 8191; on de_i fall, line_cnt SHALL increment and err_size SHALL be set if the count is not 2*H_ACT.
REQ-014 The de_i fall that brings line_cnt to V_ACT SHALL pulse frame_done the next cycle; further bytes SHALL stay gated (de_o=0) until the frame ends.
REQ-015 A rise in CAPTURE before V_ACT lines SHALL set err_size and pulse frame_done, and that rise SHALL be consumed.
REQ-016 At frame end the FSM SHALL go to IDLE if single=1 or stop is pending, else to WAIT_VS.
REQ-017 stop in CAPTURE SHALL set stop_pending (cleared in IDLE); stop in SKIP or WAIT_VS SHALL go to IDLE next cycle without a frame_done.
REQ-018 start while busy=1 SHALL be ignored; line_cnt SHALL hold its final value in IDLE.

Reset
REQ-019 While rst=1 at a pclk edge, the block SHALL enter IDLE and clear the warm-up flag, skip counter, stop_pending, byte counter and vs_d/de_d; all outputs SHALL be 0.
REQ-020 Reset asserted mid-frame SHALL take effect at the next edge, with no frame_done pulse.

Configuration
REQ-021 With macro CMOS_CAPTURE_STATS_EN defined, the block SHALL add outputs frame_cnt[15:0] (increments on each frame_done, wraps) and err_cnt[7:0] (increments on each err_size-setting event, saturates at 255), both reset to 0.
REQ-022 Without CMOS_CAPTURE_STATS_EN those ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-023 Bench with SKIP_FRAMES=2, H_ACT=4, V_ACT=3: start, single=0 -> first two vs rises produce no de_o; frame_start one cycle after the third rise.
REQ-024 Bench: 3 lines of 8 bytes -> de_o/pdata_o match input delayed 1 cycle; frame_done after the third de fall; line_cnt=3; err_size=0.
REQ-025 Bench: a line of 7 bytes -> err_size=1 after that line's de fall; err_cnt=1 with CMOS_CAPTURE_STATS_EN.
REQ-026 Bench: vs rise after 2 lines -> err_size=1, frame_done pulse, state WAIT_VS.
REQ-027 Bench: stop mid-frame -> frame completes with frame_done, then busy=0; start with stop in the same cycle -> busy stays 0.
REQ-028 Bench: rst=1 mid-line -> next cycle de_o=0, busy=0, no frame_done; the following start re-runs SKIP.

Source files
------------

// File: rtl/cmos_capture_ctrl.sv
// Camera capture gate: warm-up frame skipping, vsync-framed capture with line/size checks.
// Optional frame/error counters are compiled in with `define CMOS_CAPTURE_STATS_EN.
module cmos_capture_ctrl #(
  parameter int unsigned SKIP_FRAMES = 10,
  parameter int unsigned H_ACT       = 1280,
  parameter int unsigned V_ACT       = 720
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        start,
  input  logic        single,
  input  logic        stop,
  input  logic        vs_i,
  input  logic        de_i,
  input  logic [7:0]  pdata_i,
  output logic        de_o,
  output logic [7:0]  pdata_o,
  output logic        frame_start,
  output logic        frame_done,
  output logic        busy,
  output logic [11:0] line_cnt,
  output logic        err_size
`ifdef CMOS_CAPTURE_STATS_EN
  ,
  output logic [15:0] frame_cnt,
  output logic [7:0]  err_cnt
`endif
);

  localparam logic [12:0] LINE_BYTES = 13'(2 * H_ACT);
  localparam logic [11:0] V_LINES    = 12'(V_ACT);
  localparam logic [7:0]  SKIP_N     = 8'(SKIP_FRAMES);
  localparam logic        HAS_SKIP   = (SKIP_FRAMES != 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SKIP,
    ST_WAIT_VS,
    ST_CAPTURE
  } state_t;

  state_t      state_q;
  logic        vs_d_q;
  logic        de_d_q;
  logic        warm_done_q;
  logic        stop_pend_q;
  logic        single_q;
  logic        partial_q;
  logic [7:0]  skip_cnt_q;
  logic [12:0] byte_cnt_q;
  logic [11:0] line_cnt_q;
  logic        de_o_q;
  logic [7:0]  pdata_o_q;
  logic        frame_start_q;
  logic        frame_done_q;
  logic        err_size_q;

  logic        vs_rise;
  logic        de_fall;
  logic        in_capture;
  logic        byte_ok;
  logic        line_fall;
  logic        line_bad;
  logic        frame_full;
  logic        early_vs;
  logic        frame_end;
  logic        err_evt;
  logic        end_to_idle;
  logic [11:0] line_cnt_d;
  logic [7:0]  skip_cnt_d;

  assign vs_rise     = vs_i & ~vs_d_q;
  assign de_fall     = ~de_i & de_d_q;
  assign in_capture  = (state_q == ST_CAPTURE);
  assign byte_ok     = in_capture & de_i & ~partial_q & ~vs_rise;
  assign line_fall   = in_capture & de_fall & ~partial_q;
  assign line_cnt_d  = line_cnt_q + 12'd1;
  assign skip_cnt_d  = skip_cnt_q + 8'd1;
  assign line_bad    = (byte_cnt_q != LINE_BYTES);
  assign frame_full  = line_fall & (line_cnt_d == V_LINES);
  // A vsync that lands together with the closing line edge is treated as a clean frame end.
  assign early_vs    = in_capture & vs_rise & ~frame_full;
  assign frame_end   = frame_full | early_vs;
  assign err_evt     = (line_fall & line_bad) | early_vs;
  assign end_to_idle = single_q | stop_pend_q | stop;

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      vs_d_q        <= 1'b0;
      de_d_q        <= 1'b0;
      warm_done_q   <= 1'b0;
      stop_pend_q   <= 1'b0;
      single_q      <= 1'b0;
      partial_q     <= 1'b0;
      skip_cnt_q    <= 8'd0;
      byte_cnt_q    <= 13'd0;
      line_cnt_q    <= 12'd0;
      de_o_q        <= 1'b0;
      pdata_o_q     <= 8'd0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      err_size_q    <= 1'b0;
    end else begin
      vs_d_q        <= vs_i;
      de_d_q        <= de_i;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      de_o_q        <= byte_ok;

      if (byte_ok) begin
        pdata_o_q <= pdata_i;
        if (byte_cnt_q != 13'h1FFF) begin
          byte_cnt_q <= byte_cnt_q + 13'd1;
        end
      end

      case (state_q)
        ST_IDLE: begin
          stop_pend_q <= 1'b0;
          if (start && !stop) begin
            single_q   <= single;
            err_size_q <= 1'b0;
            if (!warm_done_q && HAS_SKIP) begin
              state_q <= ST_SKIP;
            end else begin
              state_q <= ST_WAIT_VS;
            end
          end
        end

        ST_SKIP: begin
          if (stop) begin
            state_q <= ST_IDLE;
          end else if (vs_rise) begin
            skip_cnt_q <= skip_cnt_d;
            if (skip_cnt_d == SKIP_N) begin
              warm_done_q <= 1'b1;
              state_q     <= ST_WAIT_VS;
            end
          end
        end

        ST_WAIT_VS: begin
          if (stop) begin
            state_q <= ST_IDLE;
          end else if (vs_rise) begin
            state_q       <= ST_CAPTURE;
            frame_start_q <= 1'b1;
            line_cnt_q    <= 12'd0;
            byte_cnt_q    <= 13'd0;
            // Sensor already mid-line at the frame edge: drop that line until de_i drops.
            partial_q     <= de_i;
          end
        end

        ST_CAPTURE: begin
          if (stop) begin
            stop_pend_q <= 1'b1;
          end
          if (de_fall && partial_q) begin
            partial_q <= 1'b0;
          end
          if (line_fall) begin
            line_cnt_q <= line_cnt_d;
            byte_cnt_q <= 13'd0;
          end
          if (err_evt) begin
            err_size_q <= 1'b1;
          end
          if (frame_end) begin
            frame_done_q <= 1'b1;
            state_q      <= end_to_idle ? ST_IDLE : ST_WAIT_VS;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign de_o        = de_o_q;
  assign pdata_o     = pdata_o_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign busy        = (state_q != ST_IDLE);
  assign line_cnt    = line_cnt_q;
  assign err_size    = err_size_q;

`ifdef CMOS_CAPTURE_STATS_EN
  logic [15:0] frame_cnt_q;
  logic [7:0]  err_cnt_q;

  always_ff @(posedge pclk) begin
    if (rst) begin
      frame_cnt_q <= 16'd0;
      err_cnt_q   <= 8'd0;
    end else begin
      if (frame_end) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
      if (err_evt && (err_cnt_q != 8'hFF)) begin
        err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_cmos_capture_ctrl.sv
// Directed bench for cmos_capture_ctrl with SKIP_FRAMES=2, H_ACT=4, V_ACT=3.
module tb_cmos_capture_ctrl;

  logic        pclk = 1'b0;
  logic        rst;
  logic        start;
  logic        single;
  logic        stop;
  logic        vs_i;
  logic        de_i;
  logic [7:0]  pdata_i;
  logic        de_o;
  logic [7:0]  pdata_o;
  logic        frame_start;
  logic        frame_done;
  logic        busy;
  logic [11:0] line_cnt;
  logic        err_size;
`ifdef CMOS_CAPTURE_STATS_EN
  logic [15:0] frame_cnt;
  logic [7:0]  err_cnt;
`endif

  int total = 0;
  int bad   = 0;
  int fd_cnt  = 0;
  int deo_cnt = 0;

  cmos_capture_ctrl #(
    .SKIP_FRAMES(2),
    .H_ACT(4),
    .V_ACT(3)
  ) dut (
    .pclk(pclk),
    .rst(rst),
    .start(start),
    .single(single),
    .stop(stop),
    .vs_i(vs_i),
    .de_i(de_i),
    .pdata_i(pdata_i),
    .de_o(de_o),
    .pdata_o(pdata_o),
    .frame_start(frame_start),
    .frame_done(frame_done),
    .busy(busy),
    .line_cnt(line_cnt),
    .err_size(err_size)
`ifdef CMOS_CAPTURE_STATS_EN
    ,
    .frame_cnt(frame_cnt),
    .err_cnt(err_cnt)
`endif
  );

  always #5 pclk = ~pclk;

  always @(negedge pclk) begin
    if (frame_done === 1'b1) fd_cnt++;
    if (de_o === 1'b1) deo_cnt++;
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic vs_pulse(output logic fs, output logic fd);
    vs_i = 1'b1;
    tick();
    fs = frame_start;
    fd = frame_done;
    vs_i = 1'b0;
    tick();
  endtask

  task automatic send_line(input int n, input logic [7:0] base);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = base + 8'(i);
      de_i = 1'b1;
      pdata_i = b;
      tick();
      chk("de_o_byte", de_o, 1);
      chk("pdata_o_byte", pdata_o, b);
    end
    de_i = 1'b0;
    tick();
    chk("de_o_after_line", de_o, 0);
    $display("line: %0d bytes base=%0h line_cnt=%0d err=%0b done=%0b", n, base, line_cnt, err_size, frame_done);
  endtask

  task automatic idle_bytes(input int n);
    for (int i = 0; i < n; i++) begin
      de_i = 1'b1;
      pdata_i = 8'hE0 + 8'(i);
      tick();
    end
    de_i = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic fs;
    logic fd;
    int   snap;

    rst = 1'b1; start = 1'b0; single = 1'b0; stop = 1'b0;
    vs_i = 1'b0; de_i = 1'b0; pdata_i = 8'h00;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_de_o", de_o, 0);
    chk("rst_pdata_o", pdata_o, 0);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_line_cnt", line_cnt, 0);
    chk("rst_err_size", err_size, 0);
    rst = 1'b0;
    tick();

    // Continuous start: two warm-up frames discarded.
    start = 1'b1; single = 1'b0;
    tick();
    start = 1'b0;
    chk("start_busy", busy, 1);
    snap = deo_cnt;
    vs_pulse(fs, fd);
    chk("skip1_fs", fs, 0);
    idle_bytes(4);
    vs_pulse(fs, fd);
    chk("skip2_fs", fs, 0);
    idle_bytes(4);
    chk("skip_no_de_o", deo_cnt - snap, 0);
    vs_pulse(fs, fd);
    chk("frame1_fs", fs, 1);
    chk("frame1_line_cnt0", line_cnt, 0);
    $display("frame1 start");

    // Frame 1: three good lines.
    send_line(8, 8'h10);
    chk("f1_line1", line_cnt, 1);
    send_line(8, 8'h20);
    send_line(8, 8'h30);
    chk("f1_done", frame_done, 1);
    chk("f1_line_cnt", line_cnt, 3);
    chk("f1_err", err_size, 0);
    chk("f1_busy_wait", busy, 1);
    tick();
    chk("f1_done_pulse", frame_done, 0);

    // Frame 2: short line, then early vsync.
    vs_pulse(fs, fd);
    chk("frame2_fs", fs, 1);
    send_line(7, 8'h40);
    chk("f2_short_err", err_size, 1);
    chk("f2_short_line_cnt", line_cnt, 1);
`ifdef CMOS_CAPTURE_STATS_EN
    chk("f2_err_cnt", err_cnt, 1);
`endif
    send_line(8, 8'h50);
    chk("f2_line_cnt2", line_cnt, 2);
    vs_pulse(fs, fd);
    chk("f2_early_done", fd, 1);
    chk("f2_early_consumed", fs, 0);
    chk("f2_early_err", err_size, 1);
    chk("f2_busy_wait", busy, 1);
    $display("frame2 ended by early vsync");

    // Frame 3: partial line at entry is suppressed, stop mid-frame.
    snap = deo_cnt;
    de_i = 1'b1; pdata_i = 8'hAA; vs_i = 1'b1;
    tick();
    chk("f3_fs", frame_start, 1);
    vs_i = 1'b0;
    tick();
    tick();
    de_i = 1'b0;
    tick();
    chk("f3_partial_no_de_o", deo_cnt - snap, 0);
    chk("f3_partial_line_cnt", line_cnt, 0);
    send_line(8, 8'h60);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("f3_stop_busy", busy, 1);
    send_line(8, 8'h70);
    send_line(8, 8'h30);
    chk("f3_done", frame_done, 1);
    chk("f3_busy_idle", busy, 0);
    chk("f3_line_cnt", line_cnt, 3);
    tick();
    chk("f3_hold_line_cnt", line_cnt, 3);
    chk("f3_hold_pdata", pdata_o, 8'h37);
    chk("f3_idle_de_o", de_o, 0);
    $display("frame3 stopped");

    // start with stop in the same cycle is ignored.
    start = 1'b1; stop = 1'b1; single = 1'b0;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("startstop_busy", busy, 0);
    chk("startstop_err_kept", err_size, 1);

    // Single-shot start, warm-up already done; reset mid-line.
    start = 1'b1; single = 1'b1;
    tick();
    start = 1'b0;
    chk("s1_busy", busy, 1);
    chk("s1_err_cleared", err_size, 0);
    vs_pulse(fs, fd);
    chk("s1_no_skip_fs", fs, 1);
    for (int i = 0; i < 3; i++) begin
      de_i = 1'b1; pdata_i = 8'h80 + 8'(i);
      tick();
      chk("s1_de_o", de_o, 1);
    end
    snap = fd_cnt;
    rst = 1'b1;
    tick();
    chk("rst_mid_de_o", de_o, 0);
    chk("rst_mid_busy", busy, 0);
    rst = 1'b0; de_i = 1'b0;
    tick();
    chk("rst_mid_no_done", fd_cnt - snap, 0);
    $display("reset mid-line");

    // Start after reset re-runs warm-up; start while busy is ignored.
    start = 1'b1; single = 1'b1;
    tick();
    start = 1'b0;
    chk("s2_busy", busy, 1);
    vs_pulse(fs, fd);
    chk("s2_skip1_fs", fs, 0);
    vs_pulse(fs, fd);
    chk("s2_skip2_fs", fs, 0);
    vs_pulse(fs, fd);
    chk("s2_fs", fs, 1);
    send_line(8, 8'h90);
    start = 1'b1; single = 1'b0;
    tick();
    start = 1'b0;
    send_line(8, 8'hA0);
    send_line(8, 8'hB0);
    chk("s2_done", frame_done, 1);
    chk("s2_busy_idle", busy, 0);
    chk("s2_line_cnt", line_cnt, 3);
    chk("s2_err", err_size, 0);
    tick();
    chk("total_frame_done", fd_cnt, 4);
`ifdef CMOS_CAPTURE_STATS_EN
    chk("stats_frame_cnt", frame_cnt, 1);
    chk("stats_err_cnt", err_cnt, 0);
`endif
    $display("single frame after reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
